mpmc11_strm_write_fifo: RTL and testbench
=========================================

MPMC11_STRM_WRITE_FIFO -- requirements
Module: mpmc11_strm_write_fifo

Interface
REQ-001 Parameter DEPTH, default 32: FIFO entries; power of two, 4..256.
REQ-002 Parameter STRIP_LEN, default 4: beats per full memory strip; 1..DEPTH.
REQ-003 Parameter TIMEOUT, default 15: idle cycles before a partial strip is flushed; 1..255.
REQ-004 Port clk, input, 1: single clock for all logic.
REQ-005 Port rst, input, 1: reset; one clock, reset asynchronous and active-high.
REQ-006 Port wr, input, 1: write beat offered by the stream master.
REQ-007 Port wadr, input, 32: byte address of the beat.
REQ-008 Port wdat, input, WIDX8: beat data.
REQ-009 Port wsel, input, WIDX8/8: byte enables.
REQ-010 Port wrdy, output, 1: FIFO can accept a beat this cycle.
REQ-011 Port flush, input, 1: force issue of any buffered partial strip.
REQ-012 Port mem_req, output, 1: beat presented to the controller.
REQ-013 Port mem_adr, output, 32: address of the presented beat.
REQ-014 Port mem_dat, output, WIDX8: data of the presented beat.
REQ-015 Port mem_sel, output, WIDX8/8: byte enables of the presented beat.
REQ-016 Port mem_last, output, 1: presented beat ends the strip.
REQ-017 Port mem_ack, input, 1: controller consumed the presented beat.
REQ-018 Port strip_done, output, 1: one-cycle pulse after a strip's last beat is acked.

Function
REQ-019 Beat accepted when wr & wrdy; wrdy = (count < DEPTH); a wr with wrdy low is dropped, with no state change.
REQ-020 Storage is a circular buffer; read and write pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
REQ-021 Simultaneous accept and pop in one cycle leave count unchanged.
REQ-022 FSM states: IDLE, GATHER, ISSUE, DONE.
REQ-023 IDLE -> GATHER when count becomes nonzero.
REQ-024 GATHER -> ISSUE when count >= STRIP_LEN, flush is high with count > 0, or the timeout fires (REQ-037).
REQ-025 On entering ISSUE, strip length is latched: min(count, STRIP_LEN), further truncated at the first entry whose address is not the previous entry's address + WIDX8/8.
REQ-026 In ISSUE, mem_req is high and mem_adr/mem_dat/mem_sel show the head entry; the entry pops on mem_ack.
REQ-027 mem_last is high on the final beat of the latched strip length.
REQ-028 An acked beat with mem_last high moves the FSM to DONE.
REQ-029 DONE pulses strip_done for one cycle, then goes to GATHER if count > 0, otherwise to IDLE.
REQ-030 Outputs are registered; mem_req must not drop, and mem_* must not change, while a beat is un-acked.
REQ-031 First mem_req occurs no earlier than 2 cycles after the accepting edge of the beat.
REQ-032 Beats accepted during ISSUE do not extend the latched strip.
REQ-033 Timeout counter clears on every accepted beat and on leaving GATHER.

Reset
REQ-034 rst asserted asynchronously clears pointers, count, timeout counter, FSM (IDLE), mem_req, mem_last, strip_done and mem_adr/mem_dat/mem_sel to 0; wrdy is 1 after reset.
REQ-035 rst mid-strip discards all buffered beats; no strip_done is produced.
REQ-036 Logic resumes on the first clk edge after rst deasserts.

Configuration
REQ-037 With MPMC11_STRM_WRITE_TIMEOUT_EN defined, GATHER with count > 0 and no accepted beat for TIMEOUT consecutive cycles triggers ISSUE.
REQ-038 Without MPMC11_STRM_WRITE_TIMEOUT_EN, the timeout counter is absent, and partial strips issue only on flush.

Verification
REQ-039 Four contiguous beats at 0x1000, 0x1020, 0x1040, 0x1060 (STRIP_LEN=4), mem_ack always high -> 4 mem_req beats in address order, mem_last on 0x1060, then one strip_done pulse.
REQ-040 Beats at 0x2000, 0x2020, 0x3000 -> strip of 2 ending at 0x2020 with mem_last, then a strip of 1 at 0x3000.
REQ-041 32 beats with mem_ack low, then a 33rd wr -> wrdy low after the 32nd beat, 33rd beat dropped, count stays 32.
REQ-042 With the macro defined: 1 beat then 15 idle cycles -> single-beat strip with mem_last; without the macro: no mem_req until flush, then the same strip.
REQ-043 rst pulsed after 2 beats of a 4-beat strip are acked -> mem_req low immediately, no strip_done, wrdy high, count 0.
REQ-044 mem_ack held low 5 cycles mid-strip -> mem_adr/mem_dat stable and mem_req high throughout.

Source files
------------

// File: rtl/mpmc11_strm_write_fifo.sv
// Stream write FIFO: buffers beats and issues them as address-contiguous strips to a memory controller.
// Optional idle-timeout flush of partial strips is enabled by defining MPMC11_STRM_WRITE_TIMEOUT_EN.
module mpmc11_strm_write_fifo #(
  parameter int DEPTH     = 32,
  parameter int STRIP_LEN = 4,
  parameter int TIMEOUT   = 15,
  parameter int WID       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr,
  input  logic [31:0]          wadr,
  input  logic [WID*8-1:0]     wdat,
  input  logic [WID-1:0]       wsel,
  output logic                 wrdy,
  input  logic                 flush,
  output logic                 mem_req,
  output logic [31:0]          mem_adr,
  output logic [WID*8-1:0]     mem_dat,
  output logic [WID-1:0]       mem_sel,
  output logic                 mem_last,
  input  logic                 mem_ack,
  output logic                 strip_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [CW-1:0] STRIP_LEN_C = CW'(STRIP_LEN);
  localparam logic [31:0]   STRIDE_C    = 32'(WID);

  if (DEPTH < 4 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two in 4..256");
  end
  if (STRIP_LEN < 1 || STRIP_LEN > DEPTH) begin : g_bad_strip
    $error("STRIP_LEN must be in 1..DEPTH");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATHER = 2'd1,
    ISSUE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  logic [31:0]      adr_mem [DEPTH];
  logic [WID*8-1:0] dat_mem [DEPTH];
  logic [WID-1:0]   sel_mem [DEPTH];

  state_t           state_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt_s;
  logic [CW-1:0]    strip_left_r;
  logic [CW-1:0]    strip_len_s;
  logic [AW-1:0]    head_nxt_s;
  logic             stop_s;
  logic             accept_s;
  logic             pop_s;
  logic             tmo_fire_s;
  logic             issue_go_s;

  assign accept_s   = wr & wrdy;
  assign pop_s      = mem_req & mem_ack;
  assign head_nxt_s = rd_ptr_r + AW'(1);
  assign issue_go_s = (count_r >= STRIP_LEN_C) || (flush && (count_r != {CW{1'b0}})) || tmo_fire_s;

`ifdef MPMC11_STRM_WRITE_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  logic [7:0] tmo_cnt_r;

  // Fires on the TIMEOUT-th consecutive GATHER cycle without an accepted beat.
  assign tmo_fire_s = (state_r == GATHER) && !accept_s && (tmo_cnt_r >= (TIMEOUT_C - 8'd1));

  // Idle-cycle counter, cleared on accepts and whenever GATHER is left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_r <= 8'd0;
    end else if ((state_r == GATHER) && !accept_s && !issue_go_s) begin
      tmo_cnt_r <= tmo_cnt_r + 8'd1;
    end else begin
      tmo_cnt_r <= 8'd0;
    end
  end
`else
  assign tmo_fire_s = 1'b0;
`endif

  // Next occupancy: accept and pop in the same cycle cancel out.
  always_comb begin
    count_nxt_s = count_r;
    if (accept_s && !pop_s) begin
      count_nxt_s = count_r + CW'(1);
    end else if (!accept_s && pop_s) begin
      count_nxt_s = count_r - CW'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Strip length: up to STRIP_LEN buffered beats, cut at the first address discontinuity.
  always_comb begin
    strip_len_s = CW'(1);
    stop_s      = 1'b0;
    for (int i = 1; i < STRIP_LEN; i++) begin
      if (!stop_s && (CW'(i) < count_r) &&
          (adr_mem[rd_ptr_r + AW'(i)] == adr_mem[rd_ptr_r + AW'(i - 1)] + STRIDE_C)) begin
        strip_len_s = CW'(i + 1);
      end else begin
        stop_s = 1'b1;
      end
    end
  end

  // Beat storage; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      adr_mem[wr_ptr_r] <= wadr;
      dat_mem[wr_ptr_r] <= wdat;
      sel_mem[wr_ptr_r] <= wsel;
    end
  end

  // Pointers, occupancy and registered ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      wrdy     <= 1'b1;
    end else begin
      if (accept_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)    rd_ptr_r <= head_nxt_s;
      count_r <= count_nxt_s;
      wrdy    <= (count_nxt_s < DEPTH_C);
    end
  end

  // Strip FSM with registered memory-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      mem_req      <= 1'b0;
      mem_last     <= 1'b0;
      mem_adr      <= 32'd0;
      mem_dat      <= {(WID*8){1'b0}};
      mem_sel      <= {WID{1'b0}};
      strip_left_r <= {CW{1'b0}};
      strip_done   <= 1'b0;
    end else begin
      strip_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (count_r != {CW{1'b0}}) state_r <= GATHER;
        end
        GATHER: begin
          if (issue_go_s) begin
            state_r      <= ISSUE;
            mem_req      <= 1'b1;
            mem_adr      <= adr_mem[rd_ptr_r];
            mem_dat      <= dat_mem[rd_ptr_r];
            mem_sel      <= sel_mem[rd_ptr_r];
            mem_last     <= (strip_len_s == CW'(1));
            strip_left_r <= strip_len_s;
          end
        end
        ISSUE: begin
          if (pop_s) begin
            if (mem_last) begin
              state_r    <= DONE;
              mem_req    <= 1'b0;
              mem_last   <= 1'b0;
              strip_done <= 1'b1;
            end else begin
              mem_adr      <= adr_mem[head_nxt_s];
              mem_dat      <= dat_mem[head_nxt_s];
              mem_sel      <= sel_mem[head_nxt_s];
              mem_last     <= (strip_left_r == CW'(2));
              strip_left_r <= strip_left_r - CW'(1);
            end
          end
        end
        DONE: begin
          state_r <= (count_r != {CW{1'b0}}) ? GATHER : IDLE;
        end
        default: begin
          state_r <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpmc11_strm_write_fifo.sv
// Directed self-checking bench for mpmc11_strm_write_fifo (default parameters, 32-byte beats).
module tb_mpmc11_strm_write_fifo;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr;
  logic [31:0]  wadr;
  logic [255:0] wdat;
  logic [31:0]  wsel;
  logic         wrdy;
  logic         flush;
  logic         mem_req;
  logic [31:0]  mem_adr;
  logic [255:0] mem_dat;
  logic [31:0]  mem_sel;
  logic         mem_last;
  logic         mem_ack;
  logic         strip_done;

  int n_cmp = 0;
  int n_bad = 0;
  int sd_cnt = 0;
  logic [31:0] q_adr[$];
  logic [31:0] q_dat[$];
  logic        q_last[$];

  mpmc11_strm_write_fifo dut (
    .clk(clk), .rst(rst), .wr(wr), .wadr(wadr), .wdat(wdat), .wsel(wsel),
    .wrdy(wrdy), .flush(flush), .mem_req(mem_req), .mem_adr(mem_adr),
    .mem_dat(mem_dat), .mem_sel(mem_sel), .mem_last(mem_last),
    .mem_ack(mem_ack), .strip_done(strip_done)
  );

  always #5 clk = ~clk;

  // Record beats that will be acked on the coming rising edge.
  always @(negedge clk) begin
    if (mem_req && mem_ack) begin
      q_adr.push_back(mem_adr);
      q_dat.push_back(mem_dat[31:0]);
      q_last.push_back(mem_last);
    end
    if (strip_done) sd_cnt++;
  end

  task automatic put(input logic [31:0] a);
    wr = 1'b1; wadr = a; wdat = {8{a}}; wsel = '1;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic clear_q();
    q_adr.delete(); q_dat.delete(); q_last.delete();
  endtask

  task automatic wait_req(input string name);
    int seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (mem_req) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (seen != 1) begin n_bad++; $display("FAIL %s_wait_req: mem_req=%b required 1 within 30 cycles", name, mem_req); end
  endtask

  task automatic check_beat(input string name, input int idx, input logic [31:0] a, input logic l);
    n_cmp++;
    if (idx >= q_adr.size()) begin
      n_bad++; $display("FAIL %s_beat%0d: only %0d beats seen", name, idx, q_adr.size());
    end else if (q_adr[idx] !== a || q_last[idx] !== l || q_dat[idx] !== a) begin
      n_bad++;
      $display("FAIL %s_beat%0d: adr=%h dat=%h last=%b required adr=%h dat=%h last=%b",
               name, idx, q_adr[idx], q_dat[idx], q_last[idx], a, a, l);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({mem_req, mem_last, strip_done, wrdy} !== 4'b0001 || mem_adr !== 32'd0 ||
        mem_dat !== 256'd0 || mem_sel !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_state: req=%b last=%b sd=%b wrdy=%b adr=%h sel=%h required 0,0,0,1,0,0",
               mem_req, mem_last, strip_done, wrdy, mem_adr, mem_sel);
    end
  endtask

  task automatic test_contig();
    int sd0 = sd_cnt;
    clear_q(); mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) put(32'h1000 + 32'(i) * 32'h20);
    repeat (20) @(posedge clk); #1;
    for (int i = 0; i < 4; i++) check_beat("contig", i, 32'h1000 + 32'(i) * 32'h20, i == 3);
    n_cmp++;
    if (q_adr.size() != 4 || sd_cnt - sd0 != 1) begin
      n_bad++; $display("FAIL contig_count: beats=%0d strips=%0d required 4 and 1", q_adr.size(), sd_cnt - sd0);
    end
  endtask

  task automatic test_split();
    int sd0 = sd_cnt;
    clear_q(); mem_ack = 1'b1;
    put(32'h2000); put(32'h2020); put(32'h3000);
    flush = 1'b1;
    repeat (20) @(posedge clk); #1;
    flush = 1'b0;
    check_beat("split", 0, 32'h2000, 1'b0);
    check_beat("split", 1, 32'h2020, 1'b1);
    check_beat("split", 2, 32'h3000, 1'b1);
    n_cmp++;
    if (q_adr.size() != 3 || sd_cnt - sd0 != 2) begin
      n_bad++; $display("FAIL split_count: beats=%0d strips=%0d required 3 and 2", q_adr.size(), sd_cnt - sd0);
    end
  endtask

  task automatic test_stall();
    int sd0 = sd_cnt;
    clear_q(); mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) put(32'h4000 + 32'(i) * 32'h20);
    wait_req("stall");
    mem_ack = 1'b1; @(posedge clk); #1; mem_ack = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (mem_req !== 1'b1 || mem_adr !== 32'h4020 || mem_dat[31:0] !== 32'h4020 || mem_last !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold%0d: req=%b adr=%h dat=%h last=%b required 1,4020,4020,0",
                 c, mem_req, mem_adr, mem_dat[31:0], mem_last);
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b1;
    repeat (15) @(posedge clk); #1;
    check_beat("stall", 1, 32'h4020, 1'b0);
    check_beat("stall", 3, 32'h4060, 1'b1);
    n_cmp++;
    if (q_adr.size() != 4 || sd_cnt - sd0 != 1) begin
      n_bad++; $display("FAIL stall_count: beats=%0d strips=%0d required 4 and 1", q_adr.size(), sd_cnt - sd0);
    end
  endtask

  task automatic test_full();
    int sd0 = sd_cnt;
    int bad_adr = 0;
    clear_q(); mem_ack = 1'b0;
    for (int i = 0; i < 32; i++) put(32'h5000 + 32'(i) * 32'h20);
    n_cmp++;
    if (wrdy !== 1'b0) begin n_bad++; $display("FAIL full_wrdy: wrdy=%b required 0", wrdy); end
    put(32'hDEAD0000);
    n_cmp++;
    if (wrdy !== 1'b0) begin n_bad++; $display("FAIL full_wrdy_after_drop: wrdy=%b required 0", wrdy); end
    mem_ack = 1'b1;
    repeat (120) @(posedge clk); #1;
    foreach (q_adr[i]) if (q_adr[i] === 32'hDEAD0000) bad_adr++;
    n_cmp++;
    if (q_adr.size() != 32 || bad_adr != 0 || sd_cnt - sd0 != 8) begin
      n_bad++;
      $display("FAIL full_drain: beats=%0d dropped_seen=%0d strips=%0d required 32, 0, 8",
               q_adr.size(), bad_adr, sd_cnt - sd0);
    end
    check_beat("full", 31, 32'h5000 + 32'd31 * 32'h20, 1'b1);
    n_cmp++;
    if (wrdy !== 1'b1) begin n_bad++; $display("FAIL full_wrdy_drained: wrdy=%b required 1", wrdy); end
  endtask

  task automatic test_partial();
    int sd0 = sd_cnt;
    clear_q(); mem_ack = 1'b1;
    put(32'h6000);
`ifdef MPMC11_STRM_WRITE_TIMEOUT_EN
    repeat (40) @(posedge clk); #1;
`else
    repeat (40) @(posedge clk); #1;
    n_cmp++;
    if (q_adr.size() != 0) begin n_bad++; $display("FAIL partial_no_flush: beats=%0d required 0", q_adr.size()); end
    flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
    repeat (10) @(posedge clk); #1;
`endif
    check_beat("partial", 0, 32'h6000, 1'b1);
    n_cmp++;
    if (q_adr.size() != 1 || sd_cnt - sd0 != 1) begin
      n_bad++; $display("FAIL partial_count: beats=%0d strips=%0d required 1 and 1", q_adr.size(), sd_cnt - sd0);
    end
  endtask

  task automatic test_reset_mid();
    int sd0;
    clear_q(); mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) put(32'h7000 + 32'(i) * 32'h20);
    wait_req("rstmid");
    mem_ack = 1'b1; @(posedge clk); #1; @(posedge clk); #1; mem_ack = 1'b0;
    sd0 = sd_cnt;
    #2 rst = 1'b1; #1;
    n_cmp++;
    if (mem_req !== 1'b0 || wrdy !== 1'b1 || mem_adr !== 32'd0) begin
      n_bad++; $display("FAIL rstmid_async: req=%b wrdy=%b adr=%h required 0,1,0", mem_req, wrdy, mem_adr);
    end
    @(posedge clk); #1; rst = 1'b0;
    clear_q(); mem_ack = 1'b1; flush = 1'b1;
    repeat (10) @(posedge clk); #1;
    n_cmp++;
    if (q_adr.size() != 0 || sd_cnt != sd0) begin
      n_bad++; $display("FAIL rstmid_discard: beats=%0d strips=%0d required 0 and 0", q_adr.size(), sd_cnt - sd0);
    end
    flush = 1'b0;
    put(32'h8000);
    flush = 1'b1;
    repeat (10) @(posedge clk); #1;
    flush = 1'b0;
    check_beat("rstmid_resume", 0, 32'h8000, 1'b1);
    n_cmp++;
    if (q_adr.size() != 1) begin n_bad++; $display("FAIL rstmid_resume_count: beats=%0d required 1", q_adr.size()); end
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; wadr = 32'd0; wdat = '0; wsel = '0; flush = 1'b0; mem_ack = 1'b0;
    repeat (3) @(posedge clk); #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_contig();
    test_split();
    test_stall();
    test_full();
    test_partial();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
